// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the fetch queue unit.
package fetch_queue_unit_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam logic [6:0]  OPCODE_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fq_state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] inst;
        logic [XLEN_DEF-1:0] pc;
        logic                pred_taken;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bus: redirect, icache request/response and decoder dequeue.
interface fetch_queue_unit_if #(
    parameter int unsigned XLEN = fetch_queue_unit_pkg::XLEN_DEF
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_ready;
    logic            resp_valid;
    logic [XLEN-1:0] resp_inst;
    logic            deq_valid;
    logic [XLEN-1:0] deq_inst;
    logic [XLEN-1:0] deq_pc;
    logic            deq_pred_taken;
    logic            deq_ready;

    // Fetch unit side
    modport master (
        input  redirect_valid, redirect_pc, req_ready, resp_valid, resp_inst, deq_ready,
        output req_valid, req_addr, deq_valid, deq_inst, deq_pc, deq_pred_taken
    );

    // Environment side (icache, branch unit, decoder)
    modport slave (
        output redirect_valid, redirect_pc, req_ready, resp_valid, resp_inst, deq_ready,
        input  req_valid, req_addr, deq_valid, deq_inst, deq_pc, deq_pred_taken
    );
endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with registered head, flush and occupancy outputs.
module fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    // Next head comes from the write data when it lands in the slot being exposed
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        head_d   = (do_push && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
        if (count_d == '0) begin
            head_d = '0;
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (en_i) begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i && do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = head_q;
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC, single outstanding icache request, instruction FIFO.
// Optional JAL target prediction is enabled by defining FETCH_QUEUE_JAL_PREDICT_EN.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned     XLEN        = XLEN_DEF,
    parameter int unsigned     QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    fetch_queue_unit_if.master bus
);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

    fq_state_e       state_q;
    logic [XLEN-1:0] pc_q, req_pc_q, req_addr_q, next_pc;
    logic            req_valid_q, pred_taken, push, pop, fifo_full, fifo_empty;
    logic [CW-1:0]   count, cnt_after;
    fetch_entry_t    push_entry, head;

`ifdef FETCH_QUEUE_JAL_PREDICT_EN
    logic [XLEN-1:0] jal_imm;

    // J-type immediate, sign-extended from bit 31
    always_comb begin
        jal_imm    = {{(XLEN-20){bus.resp_inst[31]}}, bus.resp_inst[19:12],
                      bus.resp_inst[20], bus.resp_inst[30:21], 1'b0};
        pred_taken = (bus.resp_inst[6:0] == OPCODE_JAL);
        next_pc    = pred_taken ? (req_pc_q + jal_imm) : (req_pc_q + XLEN'(4));
    end
`else
    assign pred_taken = 1'b0;
    assign next_pc    = req_pc_q + XLEN'(4);
`endif

    assign push      = (state_q == WAIT) && bus.resp_valid && !bus.redirect_valid;
    assign pop       = !fifo_empty && bus.deq_ready;
    assign cnt_after = count + CW'(push) - CW'(pop);

    always_comb begin
        push_entry            = '0;
        push_entry.inst       = bus.resp_inst;
        push_entry.pc         = req_pc_q;
        push_entry.pred_taken = pred_taken;
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .en_i    (rdy_in),
        .flush_i (bus.redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Redirect gates the request combinationally so no handshake can land in that cycle
    assign bus.req_valid      = req_valid_q && !bus.redirect_valid;
    assign bus.req_addr       = req_addr_q;
    assign bus.deq_valid      = !fifo_empty;
    assign bus.deq_inst       = head.inst;
    assign bus.deq_pc         = head.pc;
    assign bus.deq_pred_taken = head.pred_taken;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_PC;
        end else if (rdy_in) begin
            if (bus.redirect_valid) begin
                pc_q       <= bus.redirect_pc;
                req_addr_q <= bus.redirect_pc;
                if ((state_q == IDLE) || bus.resp_valid) begin
                    state_q     <= IDLE;
                    req_valid_q <= 1'b1;
                end else begin
                    state_q     <= DROP;
                    req_valid_q <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.req_valid && bus.req_ready) begin
                            state_q     <= WAIT;
                            req_pc_q    <= pc_q;
                            req_valid_q <= 1'b0;
                        end else begin
                            req_valid_q <= !fifo_full || pop;
                            req_addr_q  <= pc_q;
                        end
                    end
                    WAIT: begin
                        if (bus.resp_valid) begin
                            state_q     <= IDLE;
                            pc_q        <= next_pc;
                            req_addr_q  <= next_pc;
                            req_valid_q <= (cnt_after < CW'(QUEUE_DEPTH));
                        end
                    end
                    DROP: begin
                        if (bus.resp_valid) begin
                            state_q     <= IDLE;
                            req_addr_q  <= pc_q;
                            req_valid_q <= !fifo_full || pop;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit with a transaction-level reference model.
module tb_fetch_queue_unit;
    import fetch_queue_unit_pkg::*;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b0;

    fetch_queue_unit_if #(.XLEN(XLEN)) bus ();

    fetch_queue_unit #(
        .XLEN        (XLEN),
        .QUEUE_DEPTH (DEPTH),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } mentry_t;

    // Reference model: queue of expected entries plus the outstanding-request view
    mentry_t     mq[$];
    logic [31:0] m_pc, m_req_pc;
    bit          m_out, m_want, m_armed, m_just_rst;

    // Icache responder
    bit          ic_pend;
    int          ic_cnt;
    logic [31:0] ic_inst;

    int          n_checks, n_errors;
    int          cyc, first_deq;
    logic [31:0] fired[$];
    logic [31:0] exp_a [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_pc       = RESET_PC;
        m_req_pc   = RESET_PC;
        m_out      = 1'b0;
        m_want     = 1'b0;
        m_armed    = 1'b0;
        m_just_rst = 1'b1;
    endfunction

`ifdef FETCH_QUEUE_JAL_PREDICT_EN
    function automatic logic [31:0] jal_target(input logic [31:0] pc, input logic [31:0] inst);
        int off;
        off = -1048576 * int'(inst[31]) + 4096 * int'(inst[19:12])
            + 2048 * int'(inst[20]) + 2 * int'(inst[30:21]);
        return pc + 32'(off);
    endfunction
`endif

    function automatic logic [31:0] gen_inst(input logic [31:0] pc, input bit directed);
        logic [31:0] r;
        r = $urandom;
        if (directed && (pc == 32'h8)) return 32'h0200_006F;
        if (!directed && ($urandom_range(3) == 0)) return {r[31:7], OPCODE_JAL};
        return {r[31:7], 7'h13};
    endfunction

    task automatic run_cycle(input int p_rdy, input int p_rr, input int p_dr, input int p_redir,
                             input int p_rst, input int lat_hi, input bit directed);
        bit          rst, rdy, redir, rr, dr, resp, fire, exp_rv;
        logic [31:0] rpc;
        mentry_t     e;
        @(negedge clk_in);
        rst   = ($urandom_range(999) < p_rst);
        rdy   = ($urandom_range(99) < p_rdy);
        redir = rdy && !rst && ($urandom_range(99) < p_redir);
        rpc   = $urandom & 32'hFFFF_FFFC;
        rr    = !ic_pend && ($urandom_range(99) < p_rr);
        dr    = ($urandom_range(99) < p_dr);
        resp  = 1'b0;
        if (ic_pend) begin
            if (ic_cnt > 1) ic_cnt--;
            else resp = rdy;
        end
        rst_in             = rst;
        rdy_in             = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.req_ready      = rr;
        bus.deq_ready      = dr;
        bus.resp_valid     = resp;
        bus.resp_inst      = resp ? ic_inst : $urandom;
        #1;

        exp_rv = m_armed && !redir;
        check("req_valid", bus.req_valid, exp_rv);
        if (exp_rv) check("req_addr", bus.req_addr, m_pc);
        check("deq_valid", bus.deq_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("deq_pc", bus.deq_pc, mq[0].pc);
            check("deq_inst", bus.deq_inst, mq[0].inst);
            check("deq_pred", bus.deq_pred_taken, mq[0].pred);
        end
        if (m_just_rst) begin
            check("rst_req_addr", bus.req_addr, RESET_PC);
            check("rst_deq_inst", bus.deq_inst, 32'h0);
            check("rst_deq_pc", bus.deq_pc, 32'h0);
            check("rst_deq_pred", bus.deq_pred_taken, 32'h0);
        end
        if ((first_deq < 0) && (bus.deq_valid === 1'b1)) first_deq = cyc;
        cyc++;

        fire = exp_rv && rr && rdy && !rst;
        if (fire) fired.push_back(bus.req_addr);
        if (resp) ic_pend = 1'b0;
        if (rst) begin
            model_reset();
        end else if (rdy) begin
            m_just_rst = 1'b0;
            if (redir) begin
                mq.delete();
                m_pc = rpc;
                if (m_out) begin
                    if (resp) m_out = 1'b0;
                    else      m_want = 1'b0;
                end
            end else begin
                if ((mq.size() != 0) && dr) void'(mq.pop_front());
                if (m_out && resp) begin
                    if (m_want) begin
                        e.inst = ic_inst;
                        e.pc   = m_req_pc;
`ifdef FETCH_QUEUE_JAL_PREDICT_EN
                        e.pred = (ic_inst[6:0] == 7'h6F);
                        m_pc   = e.pred ? jal_target(m_req_pc, ic_inst) : m_req_pc + 32'd4;
`else
                        e.pred = 1'b0;
                        m_pc   = m_req_pc + 32'd4;
`endif
                        mq.push_back(e);
                    end
                    m_out = 1'b0;
                end
                if (fire) begin
                    m_out    = 1'b1;
                    m_want   = 1'b1;
                    m_req_pc = m_pc;
                    ic_pend  = 1'b1;
                    ic_cnt   = $urandom_range(lat_hi, 1);
                    ic_inst  = gen_inst(m_pc, directed);
                end
            end
            m_armed = !m_out && (mq.size() < DEPTH);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ic_pend  = 1'b0;
        ic_cnt   = 0;
        ic_inst  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_inst      = '0;
        bus.deq_ready      = 1'b0;
        model_reset();
`ifdef FETCH_QUEUE_JAL_PREDICT_EN
        exp_a = '{32'h0, 32'h4, 32'h8, 32'h28};
`else
        exp_a = '{32'h0, 32'h4, 32'h8, 32'hC};
`endif

        repeat (3) run_cycle(100, 0, 0, 0, 1000, 1, 1'b1);
        cyc       = 0;
        first_deq = -1;
        fired.delete();

        // Streaming with a 1-cycle icache and an always-ready consumer
        repeat (12) run_cycle(100, 100, 100, 0, 0, 1, 1'b1);
        check("first_deq_cycle", first_deq, 3);
        for (int i = 0; i < 4; i++) begin
            check("issue_addr", (i < fired.size()) ? fired[i] : 32'hDEAD_BEEF, exp_a[i]);
        end

        // Fill to full, single pop, refill
        repeat (16) run_cycle(100, 100, 0, 0, 0, 1, 1'b0);
        run_cycle(100, 100, 100, 0, 0, 1, 1'b0);
        repeat (6) run_cycle(100, 100, 0, 0, 0, 1, 1'b0);

        // Enable held low while a request is in flight
        repeat (2) run_cycle(100, 100, 100, 0, 0, 3, 1'b0);
        repeat (5) run_cycle(0, 100, 100, 0, 0, 3, 1'b0);

        // Random traffic with redirects, stalls and enable gaps, then with resets
        repeat (2000) run_cycle(85, 70, 60, 8, 0, 3, 1'b0);
        repeat (2000) run_cycle(90, 80, 70, 5, 4, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
